// File: rtl/enemy_wave_if.sv
// Pixel-stream, missile and wave-status signals for the enemy_wave compositing stage.
// master drives the stream and missile; slave is the enemy stage itself.
interface enemy_wave_if #(
  parameter int N_ENEMIES = 3
) ();
  logic [10:0]          xpos_missile;
  logic [10:0]          ypos_missile;
  logic                 on_missle;
  logic [10:0]          vcount_in;
  logic [10:0]          hcount_in;
  logic                 vsync_in;
  logic                 vblnk_in;
  logic                 hsync_in;
  logic                 hblnk_in;
  logic [11:0]          rgb_in;
  logic [10:0]          vcount_out;
  logic [10:0]          hcount_out;
  logic                 vsync_out;
  logic                 vblnk_out;
  logic                 hsync_out;
  logic                 hblnk_out;
  logic [11:0]          rgb_out;
  logic [N_ENEMIES-1:0] alive;
  logic [3:0]           level;
  logic                 level_change;
  logic                 hit;
  logic [7:0]           kill_count;

  modport master (
    output xpos_missile, ypos_missile, on_missle, vcount_in, hcount_in,
           vsync_in, vblnk_in, hsync_in, hblnk_in, rgb_in,
    input  vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out,
           rgb_out, alive, level, level_change, hit, kill_count
  );

  modport slave (
    input  xpos_missile, ypos_missile, on_missle, vcount_in, hcount_in,
           vsync_in, vblnk_in, hsync_in, hblnk_in, rgb_in,
    output vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out,
           rgb_out, alive, level, level_change, hit, kill_count
  );
endinterface

// File: rtl/enemy_wave.sv
// Row of bouncing enemies composited into the pixel stream, with missile kills and a
// PLAY/WAIT wave controller that raises the level and respawns the row after a delay.
module enemy_wave #(
  parameter int          N_ENEMIES      = 3,
  parameter int          EN_W           = 32,
  parameter int          EN_H           = 24,
  parameter int          X_SPACING      = 64,
  parameter int          Y_TOP          = 100,
  parameter int          X_MIN          = 32,
  parameter int          X_MAX          = 768,
  parameter logic [11:0] EN_COLOR       = 12'hF00,
  parameter int          MAX_LEVEL      = 9,
  parameter int          RESPAWN_FRAMES = 60
) (
  input  logic       pclk,
  input  logic       rst,
  enemy_wave_if.slave bus
);

  localparam int          SPAN       = (N_ENEMIES - 1) * X_SPACING + EN_W;
  localparam int          FW         = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(RESPAWN_FRAMES - 1);
  localparam logic [10:0] X_MIN_C    = 11'(X_MIN);
  localparam logic [10:0] X_CLAMP    = 11'(X_MAX - SPAN);
  localparam logic [10:0] Y_LO       = 11'(Y_TOP);
  localparam logic [10:0] Y_HI       = 11'(Y_TOP + EN_H);

  typedef enum logic {S_PLAY, S_WAIT} state_e;
  typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_e;

  state_e               state_q, state_d;
  dir_e                 dir_q, dir_d;
  logic [10:0]          fx_q, fx_d;
  logic [N_ENEMIES-1:0] alive_q, alive_d;
  logic [3:0]           level_q, level_d;
  logic [FW-1:0]        frame_q, frame_d;
  logic                 level_change_q, level_change_d;
  logic                 hit_q;
  logic [7:0]           kill_count_q;
  logic                 vsync_prev_q;
  logic [10:0]          vcount_q, hcount_q;
  logic                 vsync_q, vblnk_q, hsync_q, hblnk_q;
  logic [11:0]          rgb_q, rgb_d;

  logic [N_ENEMIES-1:0] pix_box, mis_box, kill;
  logic [7:0]           kill_n;
  logic [10:0]          step;
  logic                 frame_tick;

  function automatic logic in_box(input logic [10:0] x, input logic [10:0] y,
                                  input logic [10:0] lo);
    logic [10:0] hi;
    hi = lo + 11'(EN_W);
    return (x >= lo) && (x < hi) && (y >= Y_LO) && (y < Y_HI);
  endfunction

  assign frame_tick = bus.vsync_in & ~vsync_prev_q;
  assign step       = {7'd0, level_q};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pix_box = '0;
    mis_box = '0;
    kill_n  = '0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      pix_box[i] = in_box(bus.hcount_in, bus.vcount_in, fx_q + 11'(i * X_SPACING));
      mis_box[i] = in_box(bus.xpos_missile, bus.ypos_missile, fx_q + 11'(i * X_SPACING));
    end
    kill = (state_q == S_PLAY && bus.on_missle) ? (mis_box & alive_q) : '0;
    for (int i = 0; i < N_ENEMIES; i++) kill_n = kill_n + 8'(kill[i]);
  end

  always_comb begin
    rgb_d = bus.rgb_in;
    if (state_q == S_PLAY && !bus.hblnk_in && !bus.vblnk_in && |(pix_box & alive_q))
      rgb_d = EN_COLOR;
  end

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    fx_d           = fx_q;
    level_d        = level_q;
    frame_d        = frame_q;
    level_change_d = 1'b0;
    alive_d        = alive_q & ~kill;
    if (state_q == S_PLAY) begin
      if (frame_tick) begin
        if (dir_q == DIR_RIGHT) begin
          // Widened so the overshoot test cannot wrap near the top of the 11-bit range.
          if ({1'b0, fx_q} + {1'b0, step} + 12'(SPAN) > 12'(X_MAX)) begin
            fx_d  = X_CLAMP;
            dir_d = DIR_LEFT;
          end else begin
            fx_d = fx_q + step;
          end
        end else if (fx_q < X_MIN_C + step) begin
          fx_d  = X_MIN_C;
          dir_d = DIR_RIGHT;
        end else begin
          fx_d = fx_q - step;
        end
      end
      if (alive_q == '0) begin
        state_d        = S_WAIT;
        level_change_d = 1'b1;
        frame_d        = '0;
        if (level_q < 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
      end
    end else if (frame_tick) begin
      if (frame_q == FRAME_LAST) begin
        state_d = S_PLAY;
        alive_d = '1;
        fx_d    = X_MIN_C;
        dir_d   = DIR_RIGHT;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q        <= S_PLAY;
      dir_q          <= DIR_RIGHT;
      fx_q           <= X_MIN_C;
      alive_q        <= '1;
      level_q        <= 4'd1;
      frame_q        <= '0;
      level_change_q <= 1'b0;
      hit_q          <= 1'b0;
      kill_count_q   <= '0;
      vsync_prev_q   <= 1'b0;
      vcount_q       <= '0;
      hcount_q       <= '0;
      vsync_q        <= 1'b0;
      vblnk_q        <= 1'b0;
      hsync_q        <= 1'b0;
      hblnk_q        <= 1'b0;
      rgb_q          <= '0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      fx_q           <= fx_d;
      alive_q        <= alive_d;
      level_q        <= level_d;
      frame_q        <= frame_d;
      level_change_q <= level_change_d;
      hit_q          <= |kill;
      kill_count_q   <= kill_count_q + kill_n;
      vsync_prev_q   <= bus.vsync_in;
      vcount_q       <= bus.vcount_in;
      hcount_q       <= bus.hcount_in;
      vsync_q        <= bus.vsync_in;
      vblnk_q        <= bus.vblnk_in;
      hsync_q        <= bus.hsync_in;
      hblnk_q        <= bus.hblnk_in;
      rgb_q          <= rgb_d;
    end
  end

  assign bus.vcount_out   = vcount_q;
  assign bus.hcount_out   = hcount_q;
  assign bus.vsync_out    = vsync_q;
  assign bus.vblnk_out    = vblnk_q;
  assign bus.hsync_out    = hsync_q;
  assign bus.hblnk_out    = hblnk_q;
  assign bus.rgb_out      = rgb_q;
  assign bus.alive        = alive_q;
  assign bus.level        = level_q;
  assign bus.level_change = level_change_q;
  assign bus.hit          = hit_q;
  assign bus.kill_count   = kill_count_q;

endmodule

// File: tb/tb_enemy_wave.sv
// Bench for enemy_wave: a 3-enemy default instance and an 8-enemy/40-pitch instance share
// one stimulus stream; a frame-level model predicts the selected instance's outputs.
module tb_enemy_wave;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic sel  = 1'b0;
  always #5 pclk = ~pclk;

  logic [10:0] d_h = '0, d_v = '0, d_mx = '0, d_my = '0;
  logic        d_vs = 1'b0, d_hs = 1'b0, d_hb = 1'b0, d_vb = 1'b0, d_mon = 1'b0;
  logic [11:0] d_rgb = '0;

  enemy_wave_if #(.N_ENEMIES(3)) bus3 ();
  enemy_wave_if #(.N_ENEMIES(8)) bus8 ();

  enemy_wave u_dut3 (.pclk(pclk), .rst(rst), .bus(bus3.slave));
  enemy_wave #(.N_ENEMIES(8), .X_SPACING(40)) u_dut8 (.pclk(pclk), .rst(rst), .bus(bus8.slave));

  assign bus3.hcount_in = d_h;   assign bus8.hcount_in = d_h;
  assign bus3.vcount_in = d_v;   assign bus8.vcount_in = d_v;
  assign bus3.hsync_in  = d_hs;  assign bus8.hsync_in  = d_hs;
  assign bus3.vsync_in  = d_vs;  assign bus8.vsync_in  = d_vs;
  assign bus3.hblnk_in  = d_hb;  assign bus8.hblnk_in  = d_hb;
  assign bus3.vblnk_in  = d_vb;  assign bus8.vblnk_in  = d_vb;
  assign bus3.rgb_in    = d_rgb; assign bus8.rgb_in    = d_rgb;
  assign bus3.xpos_missile = d_mx;  assign bus8.xpos_missile = d_mx;
  assign bus3.ypos_missile = d_my;  assign bus8.ypos_missile = d_my;
  assign bus3.on_missle    = d_mon; assign bus8.on_missle    = d_mon;

  logic [11:0] o_rgb;
  logic [25:0] o_tim;
  logic [7:0]  o_alive, o_kc;
  logic [3:0]  o_level;
  logic        o_lc, o_hit;

  always_comb begin
    if (sel) begin
      o_rgb   = bus8.rgb_out;
      o_tim   = {bus8.hcount_out, bus8.vcount_out, bus8.hsync_out, bus8.vsync_out,
                 bus8.hblnk_out, bus8.vblnk_out};
      o_alive = bus8.alive;
      o_kc    = bus8.kill_count;
      o_level = bus8.level;
      o_lc    = bus8.level_change;
      o_hit   = bus8.hit;
    end else begin
      o_rgb   = bus3.rgb_out;
      o_tim   = {bus3.hcount_out, bus3.vcount_out, bus3.hsync_out, bus3.vsync_out,
                 bus3.hblnk_out, bus3.vblnk_out};
      o_alive = {5'd0, bus3.alive};
      o_kc    = bus3.kill_count;
      o_level = bus3.level;
      o_lc    = bus3.level_change;
      o_hit   = bus3.hit;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Frame-level model of the selected instance.
  int       m_n = 3, m_xs = 64, m_span = 160;
  int       m_fx, m_level, m_frames, m_kills;
  bit       m_right, m_play, m_vs_prev;
  bit [7:0] m_alive;

  logic [11:0] e_rgb;
  logic [25:0] e_tim;
  logic [7:0]  e_alive, e_kc;
  logic [3:0]  e_level;
  logic        e_lc, e_hit;

  function automatic bit m_inside(int i, int x, int y);
    int lo;
    lo = m_fx + i * m_xs;
    return (x >= lo) && (x < lo + 32) && (y >= 100) && (y < 124);
  endfunction

  task automatic cycle();
    bit lit, tick, all_dead;
    int nk;
    bit [7:0] killed;
    d_rgb = 12'($urandom_range(0, 12'hEFF));
    d_hs  = 1'($urandom_range(0, 1));
    if (rst) begin
      m_fx = 32; m_right = 1; m_alive = 8'((1 << m_n) - 1); m_level = 1;
      m_play = 1; m_frames = 0; m_vs_prev = 0; m_kills = 0;
      e_rgb = '0; e_tim = '0; e_lc = 0; e_hit = 0;
    end else begin
      e_tim = {d_h, d_v, d_hs, d_vs, d_hb, d_vb};
      lit = 0; killed = '0; nk = 0;
      for (int i = 0; i < m_n; i++) begin
        if (m_alive[i] && m_inside(i, d_h, d_v)) lit = 1;
        if (m_play && d_mon && m_alive[i] && m_inside(i, d_mx, d_my)) begin
          killed[i] = 1; nk++;
        end
      end
      e_rgb    = (m_play && !d_hb && !d_vb && lit) ? 12'hF00 : d_rgb;
      tick     = d_vs && !m_vs_prev;
      all_dead = (m_alive == 0);
      e_hit    = (nk > 0);
      e_lc     = m_play && all_dead;
      m_kills  = (m_kills + nk) % 256;
      if (m_play) begin
        if (tick) begin
          if (m_right) begin
            if (m_fx + m_level + m_span > 768) begin m_fx = 768 - m_span; m_right = 0; end
            else m_fx += m_level;
          end else begin
            if (m_fx < 32 + m_level) begin m_fx = 32; m_right = 1; end
            else m_fx -= m_level;
          end
        end
        m_alive &= ~killed;
        if (all_dead) begin
          m_play = 0; m_frames = 0;
          if (m_level < 9) m_level++;
        end
      end else if (tick) begin
        if (m_frames == 59) begin
          m_play = 1; m_alive = 8'((1 << m_n) - 1); m_fx = 32; m_right = 1;
        end else m_frames++;
      end
      m_vs_prev = d_vs;
    end
    e_alive = m_alive;
    e_level = 4'(m_level);
    e_kc    = 8'(m_kills);
    @(posedge pclk);
    #1;
  endtask

  task automatic set_idle();
    d_h = '0; d_v = '0; d_vs = 0; d_hb = 0; d_vb = 0; d_mon = 0; d_mx = '0; d_my = '0;
  endtask

  task automatic render_at(input int h, input int v);
    set_idle(); d_h = 11'(h); d_v = 11'(v); cycle();
  endtask

  task automatic frame_tick();
    set_idle(); d_vs = 1; cycle(); d_vs = 0; cycle();
  endtask

  task automatic shoot(input int x, input int y);
    set_idle(); d_mx = 11'(x); d_my = 11'(y); d_mon = 1; cycle(); d_mon = 0;
  endtask

  task automatic do_reset();
    set_idle(); rst = 1; cycle(); rst = 0;
  endtask

  task automatic test_reset();
    d_h = 11'd500; d_v = 11'd110; d_vs = 1; d_hb = 1; d_vb = 1; d_mon = 1;
    d_mx = 11'd40; d_my = 11'd110; rst = 1;
    cycle();
    rst = 0;
    n_cmp++; if (o_tim !== 26'd0) begin n_fail++; $display("FAIL reset_timing got %h want 0", o_tim); end
    n_cmp++; if (o_rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got %h want 000", o_rgb); end
    n_cmp++; if (o_alive !== 8'h07) begin n_fail++; $display("FAIL reset_alive got %b want 00000111", o_alive); end
    n_cmp++; if (o_level !== 4'd1) begin n_fail++; $display("FAIL reset_level got %0d want 1", o_level); end
    n_cmp++; if ({o_lc, o_hit} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b want 00", {o_lc, o_hit}); end
    n_cmp++; if (o_kc !== 8'd0) begin n_fail++; $display("FAIL reset_kills got %0d want 0", o_kc); end
  endtask

  task automatic test_render();
    int hs [7] = '{32, 63, 96, 160, 64, 32, 40};
    int vs [7] = '{100, 123, 100, 100, 100, 124, 110};
    bit on [7] = '{1, 1, 1, 1, 0, 0, 0};
    logic [11:0] want;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_idle(); d_h = 11'(hs[k]); d_v = 11'(vs[k]); d_hb = (k == 6); cycle();
      want = on[k] ? 12'hF00 : d_rgb;
      n_cmp++;
      if (o_rgb !== want) begin
        n_fail++; $display("FAIL render_point (%0d,%0d) got %h want %h", hs[k], vs[k], o_rgb, want);
      end
      n_cmp++;
      if (o_tim !== {d_h, d_v, d_hs, d_vs, d_hb, d_vb}) begin
        n_fail++; $display("FAIL timing_lag got %h want %h", o_tim, {d_h, d_v, d_hs, d_vs, d_hb, d_vb});
      end
    end
  endtask

  task automatic test_move();
    do_reset();
    frame_tick();
    render_at(33, 100);
    n_cmp++; if (o_rgb !== 12'hF00) begin n_fail++; $display("FAIL move_step_lit got %h want F00", o_rgb); end
    render_at(32, 100);
    n_cmp++; if (o_rgb !== d_rgb) begin n_fail++; $display("FAIL move_step_vacated got %h want %h", o_rgb, d_rgb); end
    repeat (575) frame_tick();
    for (int k = 0; k < 3; k++) begin
      int edge_x;
      edge_x = (k == 2) ? 607 : 608;
      render_at(edge_x, 100);
      n_cmp++; if (o_rgb !== 12'hF00) begin n_fail++; $display("FAIL bounce_lit k=%0d got %h want F00", k, o_rgb); end
      render_at(edge_x - 1, 100);
      n_cmp++; if (o_rgb !== d_rgb) begin n_fail++; $display("FAIL bounce_clear k=%0d got %h want %h", k, o_rgb, d_rgb); end
      if (k < 2) frame_tick();
    end
  endtask

  task automatic test_hit();
    do_reset();
    shoot(40, 110);
    n_cmp++; if (o_alive !== 8'h06) begin n_fail++; $display("FAIL hit_alive got %b want 00000110", o_alive); end
    n_cmp++; if (o_hit !== 1'b1) begin n_fail++; $display("FAIL hit_pulse got %b want 1", o_hit); end
    n_cmp++; if (o_kc !== 8'd1) begin n_fail++; $display("FAIL hit_count got %0d want 1", o_kc); end
    for (int k = 0; k < 5; k++) begin
      set_idle(); d_mx = 11'd40; d_my = 11'd110; d_mon = 1; cycle();
      n_cmp++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL hit_held k=%0d got %b want 0", k, o_hit); end
    end
    d_mon = 0;
    n_cmp++; if (o_kc !== 8'd1) begin n_fail++; $display("FAIL hit_held_count got %0d want 1", o_kc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_idle(); d_vs = 1; d_mx = 11'd32; d_my = 11'd100; d_mon = 1; cycle();
    n_cmp++; if (o_alive !== 8'h06) begin n_fail++; $display("FAIL tick_hit_alive got %b want 00000110", o_alive); end
    render_at(97, 100);
    n_cmp++; if (o_rgb !== 12'hF00) begin n_fail++; $display("FAIL tick_hit_moved got %h want F00", o_rgb); end
    render_at(96, 100);
    n_cmp++; if (o_rgb !== d_rgb) begin n_fail++; $display("FAIL tick_hit_vacated got %h want %h", o_rgb, d_rgb); end
  endtask

  task automatic test_wave();
    do_reset();
    shoot(40, 110); shoot(104, 110); shoot(168, 110);
    n_cmp++; if (o_alive !== 8'h00 || o_lc !== 1'b0) begin
      n_fail++; $display("FAIL wave_cleared alive=%b lc=%b want 0/0", o_alive, o_lc); end
    set_idle(); cycle();
    n_cmp++; if (o_lc !== 1'b1 || o_level !== 4'd2) begin
      n_fail++; $display("FAIL wave_level_up lc=%b level=%0d want 1/2", o_lc, o_level); end
    set_idle(); cycle();
    n_cmp++; if (o_lc !== 1'b0) begin n_fail++; $display("FAIL wave_lc_width got %b want 0", o_lc); end
    shoot(40, 110);
    n_cmp++; if (o_hit !== 1'b0 || o_kc !== 8'd3) begin
      n_fail++; $display("FAIL wait_ignores_missile hit=%b kills=%0d want 0/3", o_hit, o_kc); end
    repeat (59) frame_tick();
    n_cmp++; if (o_alive !== 8'h00) begin n_fail++; $display("FAIL wait_early got %b want 0", o_alive); end
    frame_tick();
    n_cmp++; if (o_alive !== 8'h07) begin n_fail++; $display("FAIL respawn_alive got %b want 00000111", o_alive); end
    render_at(32, 100);
    n_cmp++; if (o_rgb !== 12'hF00) begin n_fail++; $display("FAIL respawn_origin got %h want F00", o_rgb); end
    frame_tick();
    render_at(34, 100);
    n_cmp++; if (o_rgb !== 12'hF00) begin n_fail++; $display("FAIL level2_step_lit got %h want F00", o_rgb); end
    render_at(33, 100);
    n_cmp++; if (o_rgb !== d_rgb) begin n_fail++; $display("FAIL level2_step_clear got %h want %h", o_rgb, d_rgb); end
  endtask

  task automatic clear_wave();
    for (int i = 0; i < m_n; i++) shoot(m_fx + 8 + i * m_xs, 110);
    set_idle(); cycle();
  endtask

  task automatic test_level_sat();
    do_reset();
    for (int w = 0; w < 8; w++) begin
      clear_wave();
      n_cmp++; if (o_level !== e_level) begin n_fail++; $display("FAIL level_climb w=%0d got %0d want %0d", w, o_level, e_level); end
      repeat (60) frame_tick();
    end
    clear_wave();
    n_cmp++; if (o_level !== 4'd9 || o_lc !== 1'b1) begin
      n_fail++; $display("FAIL level_saturate level=%0d lc=%b want 9/1", o_level, o_lc); end
    repeat (5) frame_tick();
    do_reset();
    n_cmp++; if (o_level !== 4'd1 || o_alive !== 8'h07) begin
      n_fail++; $display("FAIL reset_in_wait level=%0d alive=%b want 1/00000111", o_level, o_alive); end
    render_at(32, 100);
    n_cmp++; if (o_rgb !== 12'hF00) begin n_fail++; $display("FAIL reset_in_wait_draw got %h want F00", o_rgb); end
  endtask

  task automatic test_random(input int n_cycles);
    for (int c = 0; c < n_cycles; c++) begin
      int mx;
      d_h   = 11'($urandom_range(0, 850));
      d_v   = 11'($urandom_range(90, 130));
      d_vs  = ($urandom_range(0, 3) == 0);
      d_hb  = ($urandom_range(0, 7) == 0);
      d_vb  = ($urandom_range(0, 7) == 0);
      d_mon = ($urandom_range(0, 2) == 0);
      mx    = m_fx - 4 + int'($urandom_range(0, m_span + 8));
      d_mx  = 11'(mx);
      d_my  = 11'($urandom_range(96, 126));
      cycle();
      n_cmp++; if (o_rgb !== e_rgb) begin n_fail++; $display("FAIL rand_rgb c=%0d got %h want %h", c, o_rgb, e_rgb); end
      n_cmp++; if (o_tim !== e_tim) begin n_fail++; $display("FAIL rand_timing c=%0d got %h want %h", c, o_tim, e_tim); end
      n_cmp++; if (o_alive !== e_alive) begin n_fail++; $display("FAIL rand_alive c=%0d got %b want %b", c, o_alive, e_alive); end
      n_cmp++; if (o_level !== e_level) begin n_fail++; $display("FAIL rand_level c=%0d got %0d want %0d", c, o_level, e_level); end
      n_cmp++; if ({o_lc, o_hit} !== {e_lc, e_hit}) begin
        n_fail++; $display("FAIL rand_pulses c=%0d got %b want %b", c, {o_lc, o_hit}, {e_lc, e_hit}); end
      n_cmp++; if (o_kc !== e_kc) begin n_fail++; $display("FAIL rand_kills c=%0d got %0d want %0d", c, o_kc, e_kc); end
    end
  endtask

  task automatic test_wide_formation();
    sel = 1; m_n = 8; m_xs = 40; m_span = 312;
    do_reset();
    repeat (424) frame_tick();
    for (int k = 0; k < 3; k++) begin
      int edge_x;
      edge_x = (k == 2) ? 455 : 456;
      render_at(edge_x, 100);
      n_cmp++; if (o_rgb !== 12'hF00) begin n_fail++; $display("FAIL wide_bounce_lit k=%0d got %h want F00", k, o_rgb); end
      render_at(edge_x - 1, 100);
      n_cmp++; if (o_rgb !== d_rgb) begin n_fail++; $display("FAIL wide_bounce_clear k=%0d got %h want %h", k, o_rgb, d_rgb); end
      if (k < 2) frame_tick();
    end
    shoot(455 + 7 * 40 + 5, 110);
    n_cmp++; if (o_alive !== 8'h7F || o_hit !== 1'b1) begin
      n_fail++; $display("FAIL wide_kill_last alive=%b hit=%b want 01111111/1", o_alive, o_hit); end
    do_reset();
    test_random(1500);
  endtask

  initial begin
    test_reset();
    test_render();
    test_move();
    test_hit();
    test_back_to_back();
    test_wave();
    test_level_sat();
    do_reset();
    test_random(3000);
    test_wide_formation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
